// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned NSTAGE_DEF    = 7;
  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned MAX_OUTST_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 32;

  typedef enum logic [2:0] {
    STG_IF1  = 3'd0,
    STG_IF2  = 3'd1,
    STG_ID   = 3'd2,
    STG_EX   = 3'd3,
    STG_MEM1 = 3'd4,
    STG_MEM2 = 3'd5,
    STG_WB   = 3'd6
  } stage_e;

  typedef struct packed {
    logic                valid;
    logic                self;
    logic [PC_W_DEF-1:0] pc;
  } redir_req_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] stall_cycles;
    logic [CNT_W_DEF-1:0] redir_count;
  } perf_cnt_t;

  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Redirect request bus plus fetch-side handshake between pipeline and hazard controller.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = NSTAGE_DEF,
  parameter int unsigned PC_W   = PC_W_DEF
);
  logic [NSTAGE-1:0]      redir_valid;
  logic [NSTAGE-1:0]      redir_self;
  logic [NSTAGE*PC_W-1:0] redir_pc;
  logic [NSTAGE-1:0]      redir_ack;
  logic                   pc_wr_valid;
  logic [PC_W-1:0]        pc_wr_target;
  logic                   fetch_issue;
  logic                   fetch_resp;
  logic                   fetch_full;
  logic                   resp_drop;

  modport master (
    output redir_valid, redir_self, redir_pc, fetch_issue, fetch_resp,
    input  redir_ack, pc_wr_valid, pc_wr_target, fetch_full, resp_drop
  );

  modport slave (
    input  redir_valid, redir_self, redir_pc, fetch_issue, fetch_resp,
    output redir_ack, pc_wr_valid, pc_wr_target, fetch_full, resp_drop
  );
endinterface

// File: rtl/pipe_hazard_ctrl_tracker.sv
// Counts in-flight icache requests and marks responses that predate the latest redirect as stale.
module fetch_inflight_tracker
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_issue,
  input  logic fetch_resp,
  input  logic accept,
  output logic fetch_full,
  output logic resp_drop
);
  localparam int unsigned OW = cnt_bits(MAX_OUTST);
  localparam logic [OW-1:0] MAX_V = OW'(MAX_OUTST);

  logic [OW-1:0] outst;
  logic [OW-1:0] outst_next;
  logic [OW-1:0] drop_cnt;

  always_comb begin
    outst_next = outst;
    if (fetch_issue && !fetch_resp) outst_next = outst + 1'b1;
    else if (!fetch_issue && fetch_resp) outst_next = outst - 1'b1;
  end

  // A response in the same cycle frees a slot, so fetch may issue alongside it.
  assign fetch_full = (outst == MAX_V) && !fetch_resp;
  assign resp_drop  = fetch_resp && (drop_cnt != '0);

  // On redirect everything still in flight after this cycle is stale; this
  // also reloads a count left over from an earlier redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst_next;
      if (accept) drop_cnt <= outst_next;
      else if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fetch_issue && fetch_full))
        else $error("fetch issued while tracker full");
      assert (!(fetch_resp && !fetch_issue && outst == '0))
        else $error("fetch response with nothing outstanding");
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for an in-order pipeline; oldest eligible redirect wins.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE    = NSTAGE_DEF,
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stall_req,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic [NSTAGE-1:0] bubble,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  redir_count,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int unsigned KW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  logic [NSTAGE-1:0] eligible;
  logic [NSTAGE-1:0] ack;
  logic              accept;
  logic [KW-1:0]     win;
  logic [PC_W-1:0]   win_pc;
  logic              pc_wr_valid_q;
  logic [PC_W-1:0]   pc_wr_target_q;

  // A stall holds its own stage and everything younger behind it.
  always_comb begin
    logic acc;
    int unsigned idx;
    acc   = 1'b0;
    stall = '0;
    for (int unsigned n = 0; n < NSTAGE; n++) begin
      idx        = NSTAGE - 1 - n;
      acc        = acc | stall_req[idx];
      stall[idx] = acc;
    end
  end

  // Stalled requesters are not eligible; they keep requesting until released.
  assign eligible = hz.redir_valid & ~stall;

  always_comb begin
    accept = 1'b0;
    win    = '0;
    win_pc = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      if (eligible[k]) begin
        accept = 1'b1;
        win    = KW'(k);
        win_pc = hz.redir_pc[k*PC_W +: PC_W];
      end
    end
  end

  always_comb begin
    ack   = '0;
    flush = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      ack[k]   = accept && (win == KW'(k));
      flush[k] = accept && ((KW'(k) < win) || ((win == KW'(k)) && hz.redir_self[k]));
    end
    // The cycle the new PC is written, whatever fetch issued last cycle is dead.
    flush[0] = flush[0] | pc_wr_valid_q;
  end

  always_comb begin
    bubble = '0;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      bubble[k] = stall[k-1] && !stall[k] && !flush[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wr_valid_q  <= 1'b0;
      pc_wr_target_q <= '0;
      stall_cycles   <= '0;
      redir_count    <= '0;
    end else begin
      pc_wr_valid_q <= accept;
      if (accept) begin
        pc_wr_target_q <= win_pc;
        redir_count    <= redir_count + 1'b1;
      end
      if (stall[0] && !flush[0]) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign hz.redir_ack    = ack;
  assign hz.pc_wr_valid  = pc_wr_valid_q;
  assign hz.pc_wr_target = pc_wr_target_q;

  fetch_inflight_tracker #(
    .MAX_OUTST (MAX_OUTST)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_issue (hz.fetch_issue),
    .fetch_resp  (hz.fetch_resp),
    .accept      (accept),
    .fetch_full  (hz.fetch_full),
    .resp_drop   (hz.resp_drop)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a tag-keyed expectation scoreboard.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned NS = 7;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 32;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] stall_req;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;
  logic [NS-1:0] bubble;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] redir_count;

  pipe_hazard_ctrl_if #(.NSTAGE(NS), .PC_W(PW)) hz ();

  pipe_hazard_ctrl #(
    .NSTAGE    (NS),
    .PC_W      (PW),
    .MAX_OUTST (4),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_req    (stall_req),
    .stall        (stall),
    .flush        (flush),
    .bubble       (bubble),
    .stall_cycles (stall_cycles),
    .redir_count  (redir_count),
    .hz           (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic exp_push(input string tag, input logic [63:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    int          idx;
    logic [63:0] exp_v;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].tag == tag) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      exp_v = sb[idx].val;
      sb.delete(idx);
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic drive(input logic [NS-1:0] sreq, input logic [NS-1:0] rv,
                       input logic [NS-1:0] rs, input logic iss, input logic rsp);
    stall_req      = sreq;
    hz.redir_valid = rv;
    hz.redir_self  = rs;
    hz.fetch_issue = iss;
    hz.fetch_resp  = rsp;
  endtask

  task automatic set_pc(input stage_e s, input logic [PW-1:0] v);
    hz.redir_pc[int'(s)*PW +: PW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    hz.redir_pc = '0;
    drive('0, '0, '0, 1'b0, 1'b0);
    set_pc(STG_EX, 32'h0000_0100);
    set_pc(STG_WB, 32'h1c00_0000);
    set_pc(STG_MEM2, 32'h0000_0500);
    set_pc(STG_ID, 32'h0000_0240);
    repeat (2) @(posedge clk);
    settle();
    exp_push("rst_pcwr_v", 0);
    exp_push("rst_stall_cycles", 0);
    exp_push("rst_redir_count", 0);
    exp_push("rst_fetch_full", 0);
    chk("rst_pcwr_v", 64'(hz.pc_wr_valid));
    chk("rst_stall_cycles", 64'(stall_cycles));
    chk("rst_redir_count", 64'(redir_count));
    chk("rst_fetch_full", 64'(hz.fetch_full));
    tick();
    rst_n = 1'b1;
    tick();

    // stall_req[4] held three cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(7'b0010000, '0, '0, 1'b0, 1'b0);
      exp_push("stall4", 64'(7'b0011111));
      exp_push("bubble4", 64'(7'b0100000));
      exp_push("flush_stall4", 0);
      settle();
      chk("stall4", 64'(stall));
      chk("bubble4", 64'(bubble));
      chk("flush_stall4", 64'(flush));
    end
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    exp_push("stall_cycles_3", 3);
    exp_push("bubble_idle", 0);
    settle();
    chk("stall_cycles_3", 64'(stall_cycles));
    chk("bubble_idle", 64'(bubble));

    // Redirects from stages 3 and 6 in the same cycle: WB wins
    tick();
    drive('0, 7'b1001000, '0, 1'b0, 1'b0);
    exp_push("ack_6", 64'(7'b1000000));
    exp_push("flush_6", 64'(7'b0111111));
    exp_push("pcwr_v", 1);
    exp_push("pcwr_t", 64'(32'h1c00_0000));
    settle();
    chk("ack_6", 64'(hz.redir_ack));
    chk("flush_6", 64'(flush));
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    exp_push("flush_pcwr", 64'(7'b0000001));
    exp_push("pcwr_v", 0);
    settle();
    chk("pcwr_v", 64'(hz.pc_wr_valid));
    chk("pcwr_t", 64'(hz.pc_wr_target));
    chk("flush_pcwr", 64'(flush));
    tick();
    exp_push("flush_idle", 0);
    exp_push("redir_count_1", 1);
    settle();
    chk("pcwr_v", 64'(hz.pc_wr_valid));
    chk("flush_idle", 64'(flush));
    chk("redir_count_1", 64'(redir_count));

    // Redirect from stage 3 deferred by a stall at stage 4
    for (int c = 0; c < 2; c++) begin
      tick();
      drive(7'b0010000, 7'b0001000, 7'b0001000, 1'b0, 1'b0);
      exp_push("ack_deferred", 0);
      exp_push("flush_deferred", 0);
      exp_push("pcwr_v", 0);
      settle();
      chk("ack_deferred", 64'(hz.redir_ack));
      chk("flush_deferred", 64'(flush));
      if (c == 1) chk("pcwr_v", 64'(hz.pc_wr_valid));
    end
    tick();
    drive('0, 7'b0001000, 7'b0001000, 1'b0, 1'b0);
    exp_push("ack_3", 64'(7'b0001000));
    exp_push("flush_3_self", 64'(7'b0001111));
    exp_push("pcwr_v", 1);
    exp_push("pcwr_t", 64'(32'h0000_0100));
    settle();
    chk("ack_3", 64'(hz.redir_ack));
    chk("flush_3_self", 64'(flush));
    chk("pcwr_v", 64'(hz.pc_wr_valid));
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    exp_push("flush_pcwr", 64'(7'b0000001));
    exp_push("pcwr_v", 0);
    settle();
    chk("pcwr_v", 64'(hz.pc_wr_valid));
    chk("pcwr_t", 64'(hz.pc_wr_target));
    chk("flush_pcwr", 64'(flush));
    tick();
    exp_push("redir_count_2", 2);
    exp_push("stall_cycles_5", 5);
    settle();
    chk("pcwr_v", 64'(hz.pc_wr_valid));
    chk("redir_count_2", 64'(redir_count));
    chk("stall_cycles_5", 64'(stall_cycles));

    // Three fetches in flight, then a redirect: their responses are stale
    for (int c = 0; c < 3; c++) begin
      tick();
      drive('0, '0, '0, 1'b1, 1'b0);
      exp_push("full_low", 0);
      settle();
      chk("full_low", 64'(hz.fetch_full));
    end
    tick();
    drive('0, 7'b0100000, '0, 1'b0, 1'b0);
    exp_push("ack_5", 64'(7'b0100000));
    exp_push("pcwr_t", 64'(32'h0000_0500));
    settle();
    chk("ack_5", 64'(hz.redir_ack));
    tick();
    drive('0, '0, '0, 1'b1, 1'b0);
    exp_push("flush_pcwr", 64'(7'b0000001));
    settle();
    chk("flush_pcwr", 64'(flush));
    chk("pcwr_t", 64'(hz.pc_wr_target));
    for (int c = 0; c < 4; c++) begin
      tick();
      drive('0, '0, '0, 1'b0, 1'b1);
      exp_push("resp_drop_seq", (c < 3) ? 64'd1 : 64'd0);
      settle();
      chk("resp_drop_seq", 64'(hz.resp_drop));
    end
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    exp_push("redir_count_3", 3);
    settle();
    chk("redir_count_3", 64'(redir_count));

    // Fill the tracker, then a response releases it in the same cycle
    for (int c = 0; c < 4; c++) begin
      tick();
      drive('0, '0, '0, 1'b1, 1'b0);
      exp_push("full_filling", 0);
      settle();
      chk("full_filling", 64'(hz.fetch_full));
    end
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    exp_push("full_high", 1);
    settle();
    chk("full_high", 64'(hz.fetch_full));
    for (int c = 0; c < 4; c++) begin
      tick();
      drive('0, '0, '0, 1'b0, 1'b1);
      exp_push("full_resp", 0);
      exp_push("resp_keep", 0);
      settle();
      chk("full_resp", 64'(hz.fetch_full));
      chk("resp_keep", 64'(hz.resp_drop));
    end

    // Reset while a PC write is pending and two stale fetches are in flight
    for (int c = 0; c < 2; c++) begin
      tick();
      drive('0, '0, '0, 1'b1, 1'b0);
    end
    tick();
    drive('0, 7'b0000100, '0, 1'b0, 1'b0);
    exp_push("ack_2", 64'(7'b0000100));
    exp_push("pcwr_v", 1);
    settle();
    chk("ack_2", 64'(hz.redir_ack));
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    settle();
    chk("pcwr_v", 64'(hz.pc_wr_valid));
    #1;
    rst_n = 1'b0;
    #1;
    exp_push("rst_async_pcwr_v", 0);
    exp_push("rst_async_redir_count", 0);
    chk("rst_async_pcwr_v", 64'(hz.pc_wr_valid));
    chk("rst_async_redir_count", 64'(redir_count));
    tick();
    drive('0, '0, '0, 1'b0, 1'b1);
    exp_push("rst_resp_drop", 0);
    settle();
    chk("rst_resp_drop", 64'(hz.resp_drop));
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();
    drive('0, '0, '0, 1'b0, 1'b1);
    exp_push("post_rst_resp_drop", 0);
    exp_push("post_rst_pcwr_v", 0);
    exp_push("post_rst_redir_count", 0);
    exp_push("post_rst_stall_cycles", 0);
    settle();
    chk("post_rst_resp_drop", 64'(hz.resp_drop));
    chk("post_rst_pcwr_v", 64'(hz.pc_wr_valid));
    chk("post_rst_redir_count", 64'(redir_count));
    chk("post_rst_stall_cycles", 64'(stall_cycles));
    tick();
    drive('0, '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < sb.size(); i++) begin
      errors++;
      $display("FAIL %s: expected %0h never compared", sb[i].tag, sb[i].val);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
